// File: rtl/silu_pkg.sv
// Shared Q-format constants and helpers for the SiLU forward/backward stages:
// sigma-table index mapping, symmetric rounding, and sigma table generation.
package silu_pkg;

  localparam int SILU_WIDTH = 16;
  localparam int SILU_FRAC  = 8;
  localparam int ONE        = 1 << SILU_FRAC;
  localparam int RANGE_Q    = 16 << SILU_FRAC;
  localparam int ACC_WIDTH  = 2 * SILU_WIDTH + 2;

  // Fractional bits used while building the sigma table at elaboration time.
  localparam int SIG_FB = 56;

  // Round half away from zero, then drop frac fractional bits.
  function automatic logic signed [63:0] round_q(input logic signed [63:0] p, input int frac);
    logic [63:0] mag;
    mag = p[63] ? -p : p;
    mag = (mag + (64'd1 << (frac - 1))) >> frac;
    return p[63] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic int lut_index(input longint x, input longint x_min, input longint x_max,
                                   input int lut_size);
    longint xc;
    longint idx;
    xc  = (x < x_min) ? x_min : ((x > x_max) ? x_max : x);
    idx = ((xc - x_min) * longint'(lut_size - 1)) / (x_max - x_min);
    if (idx < 0) begin
      idx = 0;
    end else if (idx > longint'(lut_size - 1)) begin
      idx = longint'(lut_size - 1);
    end
    return int'(idx);
  endfunction

  // round(sigma(v) * 2^frac) for table entry i, using exact integer arithmetic:
  // e^-|v| comes from a Taylor-series e^-(2^-frac) raised to |v| by squaring.
  function automatic int sigmoid_entry(input int i, input int x_min, input int range_q,
                                       input int lut_size, input int frac);
    logic [127:0] e1;
    logic [127:0] term;
    logic [127:0] base;
    logic [127:0] res;
    logic [127:0] den;
    logic [127:0] num;
    longint       v;
    int unsigned  m;
    v    = longint'(x_min) + (longint'(i) * longint'(range_q)) / longint'(lut_size - 1);
    e1   = 128'(1) << SIG_FB;
    term = e1;
    for (int n = 1; n <= 8; n++) begin
      term = term / (128'(n) << frac);
      if ((n % 2) == 1) e1 = e1 - term;
      else              e1 = e1 + term;
    end
    m    = 32'((v < 0) ? -v : v);
    res  = 128'(1) << SIG_FB;
    base = e1;
    for (int k = 0; k < 32; k++) begin
      if (m[k]) res = (res * base) >> SIG_FB;
      base = (base * base) >> SIG_FB;
    end
    den = (128'(1) << SIG_FB) + res;
    if (v >= 0) num = 128'(1) << (SIG_FB + frac);
    else        num = res << frac;
    return int'((2 * num + den) / (2 * den));
  endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Constant sigma lookup table with a combinational read; contents are built at
// elaboration from the shared generator so forward and backward agree bit-for-bit.
module sigmoid_lut
  import silu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int LUT_SIZE = 1024,
  parameter int X_MIN_Q  = -(8 << FRAC),
  parameter int X_MAX_Q  = (8 << FRAC),
  parameter int IDX_W    = $clog2(LUT_SIZE)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] lut_mem [LUT_SIZE];

  for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_entry
    localparam int ENTRY = sigmoid_entry(gi, X_MIN_Q, X_MAX_Q - X_MIN_Q, LUT_SIZE, FRAC);
    assign lut_mem[gi] = WIDTH'(ENTRY);
  end

  assign s = lut_mem[idx];

endmodule

// File: rtl/silu_backward.sv
// Three-stage SiLU backward pass: grad_x = grad_y * sigma(x) * (1 + x * (1 - sigma(x))).
// Define SILU_BWD_SATURATE_EN to clamp the result instead of wrapping to WIDTH bits.
module silu_backward
  import silu_pkg::*;
#(
  parameter int DIM      = 1,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int LUT_SIZE = 1024,
  parameter int X_MIN_Q  = -(8 << FRAC),
  parameter int X_MAX_Q  = (8 << FRAC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] x_vec,
  input  logic [DIM*WIDTH-1:0] gy_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] gx_vec
);

  localparam int IDX_W = $clog2(LUT_SIZE);
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int DW    = WIDTH + 2;
  localparam logic signed [ACC_W-1:0] ONE_A = ACC_W'(1 << FRAC);

  logic en;
  logic v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en        = !ov_q || out_ready;
  assign in_ready  = en;
  assign out_valid = ov_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    ov_d = ov_q;
    if (en) begin
      v1_d = in_valid;
      v2_d = v1_q;
      ov_d = v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      ov_q <= ov_d;
    end
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    logic signed [WIDTH-1:0] x_in, gy_in;
    logic [IDX_W-1:0]        idx;
    logic [WIDTH-1:0]        s_lut;
    logic signed [WIDTH-1:0] x1_q, x1_d, gy1_q, gy1_d, gy2_q, gy2_d;
    logic [WIDTH-1:0]        s1_q, s1_d;
    logic signed [DW-1:0]    d2_q, d2_d;
    logic [WIDTH-1:0]        gx_q, gx_d, gx_res;
    logic signed [ACC_W-1:0] s_ext, t_acc, u_acc, d_acc, p_acc;

    assign x_in  = $signed(x_vec[gi*WIDTH +: WIDTH]);
    assign gy_in = $signed(gy_vec[gi*WIDTH +: WIDTH]);
    assign idx   = IDX_W'(lut_index(longint'(x_in), longint'(X_MIN_Q), longint'(X_MAX_Q), LUT_SIZE));

    sigmoid_lut #(
      .WIDTH    (WIDTH),
      .FRAC     (FRAC),
      .LUT_SIZE (LUT_SIZE),
      .X_MIN_Q  (X_MIN_Q),
      .X_MAX_Q  (X_MAX_Q),
      .IDX_W    (IDX_W)
    ) u_lut (
      .idx (idx),
      .s   (s_lut)
    );

    always_comb begin
      s_ext = $signed(ACC_W'(s1_q));
      t_acc = ONE_A - s_ext;
      u_acc = ACC_W'(round_q(64'(x1_q) * 64'(t_acc), FRAC));
      d_acc = ACC_W'(round_q(64'(s_ext) * (64'(ONE_A) + 64'(u_acc)), FRAC));
      p_acc = ACC_W'(round_q(64'(gy2_q) * 64'(d2_q), FRAC));
    end

`ifdef SILU_BWD_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
    always_comb begin
      gx_res = WIDTH'(p_acc);
      if (p_acc > SAT_MAX)      gx_res = WIDTH'(SAT_MAX);
      else if (p_acc < SAT_MIN) gx_res = WIDTH'(SAT_MIN);
    end
`else
    assign gx_res = WIDTH'(p_acc);
`endif

    // Data registers only load behind a valid beat to avoid needless toggling.
    always_comb begin
      x1_d  = x1_q;
      gy1_d = gy1_q;
      s1_d  = s1_q;
      d2_d  = d2_q;
      gy2_d = gy2_q;
      gx_d  = gx_q;
      if (en && in_valid) begin
        x1_d  = x_in;
        gy1_d = gy_in;
        s1_d  = s_lut;
      end
      if (en && v1_q) begin
        d2_d  = DW'(d_acc);
        gy2_d = gy1_q;
      end
      if (en && v2_q) begin
        gx_d = gx_res;
      end
    end

    always_ff @(posedge clk) begin
      x1_q  <= x1_d;
      gy1_q <= gy1_d;
      s1_q  <= s1_d;
      d2_q  <= d2_d;
      gy2_q <= gy2_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gx_q <= '0;
      else        gx_q <= gx_d;
    end

    assign gx_vec[gi*WIDTH +: WIDTH] = gx_q;
  end

endmodule

// File: tb/tb_silu_backward.sv
// Directed self-checking bench for silu_backward (Q8.8, one lane).
module tb_silu_backward;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_vec = '0;
  logic [15:0] gy_vec = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] gx_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  silu_backward #(
    .DIM      (1),
    .WIDTH    (16),
    .FRAC     (8),
    .LUT_SIZE (1024),
    .X_MIN_Q  (-2048),
    .X_MAX_Q  (2048)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_vec     (x_vec),
    .gy_vec    (gy_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gx_vec    (gx_vec)
  );

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (gx_vec !== 16'h0000) begin n_fail++; $display("FAIL reset_gx: got %h expected 0000", gx_vec); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    $display("reset: out_valid=%b gx=%h in_ready=%b", out_valid, gx_vec, in_ready);
  endtask

  task automatic run_single(input logic [15:0] x, input logic [15:0] gy, input logic [15:0] exp_gx);
    @(negedge clk);
    x_vec = x; gy_vec = gy; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early x=%h: got out_valid=%b expected 0", x, out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || gx_vec !== exp_gx)
      begin n_fail++; $display("FAIL single x=%h gy=%h: got valid=%b gx=%h expected valid=1 gx=%h", x, gy, out_valid, gx_vec, exp_gx); end
    $display("single: x=%h gy=%h gx=%h expected=%h", x, gy, gx_vec, exp_gx);
  endtask

  task automatic test_vectors();
    logic [15:0] xs  [8] = '{16'h0000, 16'h0A00, 16'hF600, 16'h0000, 16'h7FFF, 16'h0000, 16'hFF00, 16'h0100};
    logic [15:0] gys [8] = '{16'h0100, 16'h0100, 16'h1234, 16'hFF00, 16'hFF00, 16'h0200, 16'h0100, 16'h0100};
    logic [15:0] exs [8] = '{16'h007F, 16'h0100, 16'h0000, 16'hFF81, 16'hFF00, 16'h00FE, 16'h0012, 16'h00ED};
    for (int i = 0; i < 8; i++) run_single(xs[i], gys[i], exs[i]);
  endtask

  task automatic test_wide_result();
`ifdef SILU_BWD_SATURATE_EN
    run_single(16'h0266, 16'h7FFF, 16'h7FFF);
`else
    run_single(16'h0266, 16'h7FFF, 16'h8CFF);
`endif
  endtask

  // Odd beats use a clamped-negative x (gx=0); even beats clamp high so gx=gy.
  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] prev_gx = '0;
    logic [15:0] e;
    logic        prev_stall = 1'b0;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      x_vec     = (sent % 2 == 0) ? 16'h0A00 : 16'hF600;
      gy_vec    = 16'h0100 + 16'(sent * 16'h0111);
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready))
        begin n_fail++; $display("FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready); end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || gx_vec !== prev_gx)
          begin n_fail++; $display("FAIL stall_hold: got valid=%b gx=%h expected valid=1 gx=%h", out_valid, gx_vec, prev_gx); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back((sent % 2 == 0) ? gy_vec : 16'h0000);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got gx=%h expected no beat", gx_vec);
        end else begin
          e = exp_q.pop_front();
          if (gx_vec !== e) begin n_fail++; $display("FAIL stream_data beat %0d: got %h expected %h", got, gx_vec, e); end
          $display("stream: beat %0d gx=%h expected=%h", got, gx_vec, e);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_gx    = gx_vec;
    end
    n_checks++;
    if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d beats expected 8", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup: got out_valid=%b gx=%h expected idle", out_valid, gx_vec); end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; x_vec = 16'h0A00; gy_vec = 16'h0123 + 16'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || gx_vec !== 16'h0123)
      begin n_fail++; $display("FAIL midstream_pre: got valid=%b gx=%h expected 1/0123", out_valid, gx_vec); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || gx_vec !== 16'h0000)
      begin n_fail++; $display("FAIL midstream_reset: got valid=%b gx=%h expected 0/0000", out_valid, gx_vec); end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midstream_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midstream_stale: got out_valid=%b gx=%h expected 0", out_valid, gx_vec); end
    end
    $display("midstream reset: in-flight beats dropped, out_valid=%b", out_valid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_wide_result();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
